// File: rtl/cdc_fifo_pkg.sv
// Shared pointer helpers for the async CDC FIFO, used by both the read-side
// empty/level block and the write-side full/level block.
package cdc_fifo_pkg;

  // Widest pointer any FIFO instance may use. Callers widen into ptr_t and
  // truncate the result back to their own width.
  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros from the widening do not change the decoded value.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder of width W. Each binary bit is the XOR of
// all Gray bits at or above it, which gives every bit a direct cone of logic.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer, empty, almost-empty and occupancy logic of the async FIFO.
// Optional sticky underflow flag is built when RPTR_UFLOW_EN is defined.
module rptr_empty_lvl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   wptr_rclk,
  input  logic              rpop,
  input  logic              rerr_clr,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              rempty,
  output logic              ralmost_empty,
  output logic [ADDR_W:0]   rlevel,
  output logic              runderflow
);

  localparam int              PW     = ADDR_W + 1;
  localparam logic [ADDR_W:0] AE_LIM = AEMPTY_THRESH[ADDR_W:0];

  logic [ADDR_W:0] r_rbin;
  logic [ADDR_W:0] r_rptr;
  logic            r_rempty;
  logic            r_raempty;
  logic [ADDR_W:0] r_rlevel;

  logic            w_pop;
  logic [ADDR_W:0] w_rbin_next;
  logic [ADDR_W:0] w_rgray_next;
  logic [ADDR_W:0] w_wbin;
  logic [ADDR_W:0] w_lvl_next;

  gray2bin_conv #(.W(PW)) u_wdec (
    .i_gray (wptr_rclk),
    .o_bin  (w_wbin)
  );

  // Popping while empty never moves the pointer; the registered empty flag is
  // pessimistic, so an accepted pop always has data behind it.
  assign w_pop         = rpop & ~r_rempty;
  assign w_rbin_next   = r_rbin + {{ADDR_W{1'b0}}, w_pop};
  assign w_rgray_next  = PW'(bin2gray(ptr_t'(w_rbin_next)));
  assign w_lvl_next    = w_wbin - w_rbin_next;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
      r_rlevel  <= '0;
    end else begin
      r_rbin    <= w_rbin_next;
      r_rptr    <= w_rgray_next;
      r_rempty  <= (w_rgray_next == wptr_rclk);
      r_raempty <= (w_lvl_next <= AE_LIM);
      r_rlevel  <= w_lvl_next;
    end
  end

  assign rptr          = r_rptr;
  assign raddr         = r_rbin[ADDR_W-1:0];
  assign rempty        = r_rempty;
  assign ralmost_empty = r_raempty;
  assign rlevel        = r_rlevel;

`ifdef RPTR_UFLOW_EN
  logic r_runderflow;

  // Set has priority so an underflow coinciding with a clear is not lost.
  always_ff @(posedge rclk) begin
    if (rrst)                   r_runderflow <= 1'b0;
    else if (rpop && r_rempty)  r_runderflow <= 1'b1;
    else if (rerr_clr)          r_runderflow <= 1'b0;
  end

  assign runderflow = r_runderflow;
`else
  logic w_unused_clr;
  assign w_unused_clr = rerr_clr;
  assign runderflow   = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl (ADDR_W=4, AEMPTY_THRESH=2); underflow
// expectations follow RPTR_UFLOW_EN.
module tb_rptr_empty_lvl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] wptr_rclk;
  logic       rpop;
  logic       rerr_clr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int n_checks = 0;
  int n_errors = 0;

`ifdef RPTR_UFLOW_EN
  localparam logic UF_ON = 1'b1;
`else
  localparam logic UF_ON = 1'b0;
`endif

  rptr_empty_lvl #(.ADDR_W(4), .AEMPTY_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .wptr_rclk     (wptr_rclk),
    .rpop          (rpop),
    .rerr_clr      (rerr_clr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rempty"}, 32'(rempty), 32'd1);
    chk({tag, "_aempty"}, 32'(ralmost_empty), 32'd1);
    chk({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    chk({tag, "_rptr"},   32'(rptr), 32'd0);
    chk({tag, "_raddr"},  32'(raddr), 32'd0);
    chk({tag, "_uflow"},  32'(runderflow), 32'd0);
  endtask

  initial begin
    // 1: reset with rpop held high
    rrst = 1'b1; rpop = 1'b1; rerr_clr = 1'b0; wptr_rclk = 5'b00000;
    step(); step();
    chk_reset("rst");

    // 2: three words written, then drained
    rrst = 1'b0; rpop = 1'b0; wptr_rclk = 5'b00010;
    step();
    chk("w3_rempty", 32'(rempty), 32'd0);
    chk("w3_rlevel", 32'(rlevel), 32'd3);
    chk("w3_aempty", 32'(ralmost_empty), 32'd0);
    rpop = 1'b1;
    step();
    chk("pop1_rlevel", 32'(rlevel), 32'd2);
    chk("pop1_aempty", 32'(ralmost_empty), 32'd1);
    chk("pop1_raddr",  32'(raddr), 32'd1);
    step(); step();
    rpop = 1'b0;
    chk("pop3_raddr",  32'(raddr), 32'd3);
    chk("pop3_rptr",   32'(rptr), 32'b00010);
    chk("pop3_rempty", 32'(rempty), 32'd1);
    chk("pop3_rlevel", 32'(rlevel), 32'd0);

    // 3: underflow handling
    rpop = 1'b1;
    step();
    rpop = 1'b0;
    chk("uf_raddr", 32'(raddr), 32'd3);
    chk("uf_set",   32'(runderflow), 32'(UF_ON));
    rerr_clr = 1'b1;
    step();
    chk("uf_clr", 32'(runderflow), 32'd0);
    rpop = 1'b1;
    step();
    rpop = 1'b0; rerr_clr = 1'b0;
    chk("uf_set_wins", 32'(runderflow), 32'(UF_ON));
    chk("uf_raddr2",   32'(raddr), 32'd3);
    rerr_clr = 1'b1;
    step();
    rerr_clr = 1'b0;
    chk("uf_clr2", 32'(runderflow), 32'd0);

    // 4: wrap: read pointer advances to bin 16 (13 more pops)
    wptr_rclk = 5'b11000;
    step();
    chk("wrap_lvl13", 32'(rlevel), 32'd13);
    rpop = 1'b1;
    for (int i = 0; i < 13; i++) step();
    rpop = 1'b0;
    chk("wrap_rptr",   32'(rptr), 32'b11000);
    chk("wrap_raddr",  32'(raddr), 32'd0);
    chk("wrap_rempty", 32'(rempty), 32'd1);
    chk("wrap_uflow",  32'(runderflow), 32'd0);
    wptr_rclk = 5'b11110;
    step();
    chk("wrap_rlevel", 32'(rlevel), 32'd4);
    chk("wrap_ne",     32'(rempty), 32'd0);
    chk("wrap_aempty", 32'(ralmost_empty), 32'd0);

    // 5: full distance from rptr=0
    rrst = 1'b1;
    step();
    rrst = 1'b0; wptr_rclk = 5'b11000;
    step();
    chk("full_rlevel", 32'(rlevel), 32'd16);
    chk("full_rempty", 32'(rempty), 32'd0);
    chk("full_aempty", 32'(ralmost_empty), 32'd0);

    // 6: reset mid-operation at level 5, rpop held
    rrst = 1'b1;
    step();
    rrst = 1'b0; wptr_rclk = 5'b00111;
    step();
    chk("l5_rlevel", 32'(rlevel), 32'd5);
    rrst = 1'b1; rpop = 1'b1;
    step();
    chk_reset("mid_rst");

    // simultaneous pop and write-pointer advance (bin 5 -> 7, one pop)
    rrst = 1'b0; rpop = 1'b0;
    step();
    chk("sim_pre", 32'(rlevel), 32'd5);
    rpop = 1'b1; wptr_rclk = 5'b00100;
    step();
    rpop = 1'b0;
    chk("sim_rlevel", 32'(rlevel), 32'd6);
    chk("sim_raddr",  32'(raddr), 32'd1);
    chk("sim_rptr",   32'(rptr), 32'b00001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
